// File: rtl/rob.sv
// Reorder buffer: allocates tags to dispatched instructions, captures CDB
// writebacks, serves operand lookups and retires entries strictly in order.
module rob #(
  parameter int               ROB_SIZE = 16,
  parameter int               TAG_W    = 5,
  parameter int               OP_W     = 6,
  parameter logic [OP_W-1:0]  OP_SB    = OP_W'(20),
  parameter logic [OP_W-1:0]  OP_SH    = OP_W'(21),
  parameter logic [OP_W-1:0]  OP_SW    = OP_W'(22)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [OP_W-1:0]  in_dec_op,
  input  logic [31:0]      in_dec_destination,
  input  logic             in_dec_isready,
  input  logic [31:0]      in_dec_value,
  output logic [TAG_W-1:0] out_free_tag,
  output logic             out_full,
  input  logic [TAG_W-1:0] in_fetch_tag1,
  input  logic [TAG_W-1:0] in_fetch_tag2,
  output logic [31:0]      out_fetch_value1,
  output logic [31:0]      out_fetch_value2,
  output logic             out_fetch_ready1,
  output logic             out_fetch_ready2,
  input  logic             in_cdb_valid,
  input  logic [TAG_W-1:0] in_cdb_tag,
  input  logic [31:0]      in_cdb_value,
  output logic             out_commit_reg_valid,
  output logic [4:0]       out_commit_reg_dest,
  output logic [TAG_W-1:0] out_commit_reg_tag,
  output logic [31:0]      out_commit_value,
  output logic             out_commit_store_valid,
  output logic [TAG_W-1:0] out_commit_store_tag
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic [ROB_SIZE-1:0] busy, ready;

  logic [OP_W-1:0]     op_mem    [ROB_SIZE];
  logic [4:0]          dest_mem  [ROB_SIZE];
  logic [31:0]         value_mem [ROB_SIZE];

  // Only the low five bits name a register; the rest are carried by the bus.
  logic unused_dest_hi;
  assign unused_dest_hi = ^in_dec_destination[31:5];

  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(ROB_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  assign out_full     = (count == CNT_W'(ROB_SIZE));
  assign out_free_tag = out_full ? '0 : TAG_W'(tail) + TAG_W'(1);

  logic             do_dispatch, do_commit, wb_hit, head_is_store;
  logic [IDX_W-1:0] wb_idx;

  assign do_dispatch   = rdy && (in_dec_op != '0) && !out_full;
  assign do_commit     = rdy && (count != '0) && ready[head];
  assign wb_idx        = tag_idx(in_cdb_tag);
  assign wb_hit        = rdy && in_cdb_valid && tag_in_range(in_cdb_tag) && busy[wb_idx];
  assign head_is_store = (op_mem[head] == OP_SB) || (op_mem[head] == OP_SH) ||
                         (op_mem[head] == OP_SW);

  // Operand lookup, with the CDB forwarded so a value broadcast this cycle
  // is visible before it lands in the array.
  logic [TAG_W-1:0] q_tag   [2];
  logic [31:0]      q_value [2];
  logic             q_ready [2];

  assign q_tag[0] = in_fetch_tag1;
  assign q_tag[1] = in_fetch_tag2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: defaults first so every path assigns every output; no latches.
      q_value[p] = '0;
      q_ready[p] = 1'b0;
      if (tag_in_range(q_tag[p])) begin
        if (in_cdb_valid && (in_cdb_tag == q_tag[p])) begin
          q_value[p] = in_cdb_value;
          q_ready[p] = 1'b1;
        end else begin
          q_value[p] = value_mem[tag_idx(q_tag[p])];
          q_ready[p] = ready[tag_idx(q_tag[p])];
        end
      end
    end
  end

  assign out_fetch_value1 = q_value[0];
  assign out_fetch_ready1 = q_ready[0];
  assign out_fetch_value2 = q_value[1];
  assign out_fetch_ready2 = q_ready[1];

  // Control state and registered commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head                   <= '0;
      tail                   <= '0;
      count                  <= '0;
      busy                   <= '0;
      ready                  <= '0;
      out_commit_reg_valid   <= 1'b0;
      out_commit_reg_dest    <= '0;
      out_commit_reg_tag     <= '0;
      out_commit_value       <= '0;
      out_commit_store_valid <= 1'b0;
      out_commit_store_tag   <= '0;
    end else begin
      out_commit_reg_valid   <= 1'b0;
      out_commit_reg_dest    <= '0;
      out_commit_reg_tag     <= '0;
      out_commit_value       <= '0;
      out_commit_store_valid <= 1'b0;
      out_commit_store_tag   <= '0;

      if (wb_hit) ready[wb_idx] <= 1'b1;

      if (do_dispatch) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= in_dec_isready;
        tail        <= tail + IDX_W'(1);
      end

      // Head and tail coincide only when empty or full, so a dispatch and
      // a commit never touch the same entry.
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + IDX_W'(1);
        if (head_is_store) begin
          out_commit_store_valid <= 1'b1;
          out_commit_store_tag   <= TAG_W'(head) + TAG_W'(1);
        end else begin
          out_commit_reg_valid <= 1'b1;
          out_commit_reg_dest  <= dest_mem[head];
          out_commit_reg_tag   <= TAG_W'(head) + TAG_W'(1);
          out_commit_value     <= value_mem[head];
        end
      end

      case ({do_dispatch, do_commit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; busy/ready guard every read of it.
  always_ff @(posedge clk) begin
    if (do_dispatch) begin
      op_mem[tail]    <= in_dec_op;
      dest_mem[tail]  <= in_dec_destination[4:0];
      value_mem[tail] <= in_dec_value;
    end
    if (wb_hit) value_mem[wb_idx] <= in_cdb_value;
  end

endmodule
